// File: rtl/data_slicer_pkg.sv
// Shared types for the low-dim data slicer: slice-mode encodings, FSM states and
// the chunk geometry helpers used to walk a beat LSB-first.
package data_slicer_pkg;

  typedef enum logic [2:0] {
    MODE_FULL = 3'd0,
    MODE_B1   = 3'd1,
    MODE_B2   = 3'd2,
    MODE_B4   = 3'd3,
    MODE_B8   = 3'd4,
    MODE_B16  = 3'd5
  } slice_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reserved encodings (6, 7) fall back to FULL, i.e. one chunk spanning the beat.
  function automatic int unsigned chunk_width(input logic [2:0] mode, input int unsigned full_w);
    case (mode)
      MODE_B1:  return 1;
      MODE_B2:  return 2;
      MODE_B4:  return 4;
      MODE_B8:  return 8;
      MODE_B16: return 16;
      default:  return full_w;
    endcase
  endfunction

  function automatic int unsigned chunks_per_beat(input logic [2:0] mode, input int unsigned low_dim_width);
    return low_dim_width / chunk_width(mode, low_dim_width);
  endfunction

endpackage

// File: rtl/fifo_buffer.sv
// Synchronous FIFO without fall-through: a pushed word becomes visible on data_o
// the cycle after the push. data_o reads as zero while empty.
module fifo_buffer #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (rd_en) rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/param_data_slicer.sv
// Slices each low-dim beat into mode-selected chunks and emits one item-memory address
// per chunk into an output FIFO. Optional SLICER_BASE_ADDR_EN adds a wrapping base offset.
module param_data_slicer #(
  parameter int LowDimWidth     = 64,
  parameter int NumTotIm        = 1024,
  parameter int SlicerFifoDepth = 4,
  parameter int CsrDataWidth    = 32,
  parameter int ModeWidth       = 3,
  parameter int ImAddrWidth     = $clog2(NumTotIm)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    start_i,
  input  logic [ModeWidth-1:0]    sel_mode_i,
  input  logic [CsrDataWidth-1:0] csr_elem_size_i,
  input  logic [ImAddrWidth-1:0]  csr_base_addr_i,
  input  logic [LowDimWidth-1:0]  lowdim_data_i,
  input  logic                    lowdim_data_valid_i,
  output logic                    lowdim_data_ready_o,
  output logic [ImAddrWidth-1:0]  addr_o,
  output logic                    addr_valid_o,
  input  logic                    addr_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  import data_slicer_pkg::*;

  localparam int CntW = $clog2(LowDimWidth);

  state_e                  state_q;
  logic [ModeWidth-1:0]    mode_q;
  logic [CsrDataWidth-1:0] elem_size_q, elem_cnt_q;
  logic [CntW-1:0]         chunk_cnt_q;
  logic                    done_q;

  logic [31:0]             chunk_w, cpb;
  logic [CntW-1:0]         shamt;
  logic [LowDimWidth-1:0]  mask, sliced;
  logic [ImAddrWidth-1:0]  slice_addr, push_addr;
  logic                    fifo_full, fifo_empty, push, pop, last_chunk, last_elem;

  assign chunk_w    = chunk_width(mode_q, LowDimWidth);
  assign cpb        = chunks_per_beat(mode_q, LowDimWidth);
  assign shamt      = CntW'(32'(chunk_cnt_q) * chunk_w);
  assign mask       = (chunk_w >= 32'(LowDimWidth)) ? '1
                    : ((LowDimWidth'(1) << chunk_w) - LowDimWidth'(1));
  assign sliced     = (lowdim_data_i >> shamt) & mask;
  // Width cast zero-extends narrow chunks and keeps only the LSBs of wide ones.
  assign slice_addr = ImAddrWidth'(sliced);

`ifdef SLICER_BASE_ADDR_EN
  assign push_addr = slice_addr + csr_base_addr_i;
`else
  logic unused_base_addr;
  assign unused_base_addr = ^csr_base_addr_i;
  assign push_addr        = slice_addr;
`endif

  assign last_chunk = (32'(chunk_cnt_q) == cpb - 32'd1);
  assign last_elem  = (elem_cnt_q == elem_size_q - CsrDataWidth'(1));
  assign push       = (state_q == RUN) && lowdim_data_valid_i && !fifo_full;
  assign pop        = addr_ready_i && !fifo_empty;

  // The beat is released on its last chunk, or early when the job ends mid-beat.
  assign lowdim_data_ready_o = push && (last_chunk || last_elem);
  assign addr_valid_o        = !fifo_empty;
  assign busy_o              = (state_q == RUN);
  assign done_o              = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      elem_size_q <= '0;
      elem_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      done_q      <= 1'b0;
    end else if (clr_i) begin
      state_q     <= IDLE;
      elem_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q      <= sel_mode_i;
            elem_size_q <= csr_elem_size_i;
            elem_cnt_q  <= '0;
            chunk_cnt_q <= '0;
            if (csr_elem_size_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (push) begin
            if (last_elem) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              elem_cnt_q  <= '0;
              chunk_cnt_q <= '0;
            end else begin
              elem_cnt_q  <= elem_cnt_q + CsrDataWidth'(1);
              chunk_cnt_q <= last_chunk ? '0 : chunk_cnt_q + CntW'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_buffer #(
    .Width (ImAddrWidth),
    .Depth (SlicerFifoDepth)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (push),
    .data_i  (push_addr),
    .pop_i   (pop),
    .data_o  (addr_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_param_data_slicer.sv
// Bench for param_data_slicer: directed jobs from the slicing rules plus random jobs,
// addresses predicted by an arithmetic chunking model and scored through exp_q.
module tb_param_data_slicer;

  localparam int LW = 64;
  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          start_i = 1'b0;
  logic [2:0]    sel_mode_i = '0;
  logic [31:0]   csr_elem_size_i = '0;
  logic [AW-1:0] csr_base_addr_i = '0;
  logic [LW-1:0] lowdim_data_i = '0;
  logic          lowdim_data_valid_i = 1'b0;
  logic          lowdim_data_ready_o;
  logic [AW-1:0] addr_o;
  logic          addr_valid_o;
  logic          addr_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [LW-1:0] beats_q[$];
  logic [AW-1:0] exp_q[$];

  param_data_slicer dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .clr_i               (clr_i),
    .start_i             (start_i),
    .sel_mode_i          (sel_mode_i),
    .csr_elem_size_i     (csr_elem_size_i),
    .csr_base_addr_i     (csr_base_addr_i),
    .lowdim_data_i       (lowdim_data_i),
    .lowdim_data_valid_i (lowdim_data_valid_i),
    .lowdim_data_ready_o (lowdim_data_ready_o),
    .addr_o              (addr_o),
    .addr_valid_o        (addr_valid_o),
    .addr_ready_i        (addr_ready_i),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // reference model: chunk width from the mode, chunks taken LSB-first from successive beats
  function automatic int mode_width(input logic [2:0] m);
    case (m)
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 4;
      3'd4: return 8;
      3'd5: return 16;
      default: return LW;
    endcase
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [2:0] m, input int idx);
    int w, per_beat;
    logic [LW-1:0] v;
    logic [AW-1:0] a;
    w = mode_width(m);
    per_beat = LW / w;
    v = beats_q[idx / per_beat] >> (w * (idx % per_beat));
    if (w < LW) v = v & ((64'd1 << w) - 64'd1);
    a = v[AW-1:0];
`ifdef SLICER_BASE_ADDR_EN
    a = a + csr_base_addr_i;
`endif
    return a;
  endfunction

  // driver: runs one job; hold = cycles with downstream ready forced low at the start
  task automatic run_job(input logic [2:0] m, input int elem, input bit rnd_vld,
                         input bit rnd_rdy, input int hold, input string tag);
    int w, nb, bidx, consumed, dones, cyc;
    w = mode_width(m);
    nb = (elem + (LW / w) - 1) / (LW / w);
    exp_q.delete();
    for (int i = 0; i < elem; i++) exp_q.push_back(model_addr(m, i));
    bidx = 0; consumed = 0; dones = 0; cyc = 0;
    @(negedge clk_i);
    sel_mode_i = m;
    csr_elem_size_i = elem;
    start_i = 1'b1;
    lowdim_data_valid_i = 1'b0;
    addr_ready_i = 1'b0;
    while (cyc < 1000) begin
      @(negedge clk_i);
      start_i = 1'b0;
      // scramble the job inputs: they were latched at start
      sel_mode_i = 3'($urandom_range(0, 7));
      csr_elem_size_i = $urandom_range(0, 40);
      addr_ready_i = (cyc < hold) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      lowdim_data_valid_i = (bidx < beats_q.size()) && (rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1);
      lowdim_data_i = (bidx < beats_q.size()) ? beats_q[bidx] : {$urandom, $urandom};
      #1;
      if (hold > 0 && cyc == hold - 1) begin
        chk({tag, "_stall_in_ready"}, 64'(lowdim_data_ready_o), 64'd0);
        chk({tag, "_stall_valid"}, 64'(addr_valid_o), 64'd1);
        chk({tag, "_stall_busy"}, 64'(busy_o), 64'd1);
      end
      if (addr_valid_o && addr_ready_i) begin
        if (exp_q.size() == 0) chk({tag, "_extra_addr"}, 64'(addr_o), 64'h3ff_dead);
        else chk({tag, "_addr"}, 64'(addr_o), 64'(exp_q.pop_front()));
      end
      if (lowdim_data_valid_i && lowdim_data_ready_o) begin
        bidx++;
        consumed++;
      end
      if (done_o) begin
        dones++;
        chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
      end
      cyc++;
      if (dones > 0 && exp_q.size() == 0 && !addr_valid_o) break;
    end
    chk({tag, "_done_count"}, 64'(dones), 64'd1);
    chk({tag, "_addrs_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_beats_used"}, 64'(consumed), 64'(nb));
    @(negedge clk_i);
    lowdim_data_valid_i = 1'b0;
    #1;
    chk({tag, "_done_one_cycle"}, 64'(done_o), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [2:0] m;
    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_addr_valid", 64'(addr_valid_o), 64'd0);
    chk("rst_in_ready", 64'(lowdim_data_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_i = 1'b0;

    // 4b mode, nibble ramp
    beats_q = '{64'hFEDC_BA98_7654_3210};
    run_job(3'd3, 16, 1'b0, 1'b0, 0, "b4_ramp");

    // 1b mode, job ends mid-beat
    beats_q = '{64'h5};
    run_job(3'd1, 3, 1'b0, 1'b0, 0, "b1_trunc");

    // 8b mode with downstream stalled until the FIFO fills
    beats_q = '{64'h8877_6655_4433_2211, 64'h0123_4567_89AB_CDEF};
    run_job(3'd4, 12, 1'b0, 1'b0, 10, "b8_stall");

    // FULL mode, one address per beat
    beats_q = '{64'h3FF, 64'h123};
    run_job(3'd0, 2, 1'b0, 1'b0, 0, "full");

    // zero-length job: straight to done
    beats_q = '{64'hABCD};
    run_job(3'd2, 0, 1'b0, 1'b0, 0, "zero_len");

    // base offset wraps (or plain nibbles without the offset)
    csr_base_addr_i = 10'h3FE;
    beats_q = '{64'h21};
    run_job(3'd3, 2, 1'b0, 1'b0, 0, "base_wrap");
    csr_base_addr_i = '0;

    // 16b mode, clear after three pushes, then restart
    beats_q = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    @(negedge clk_i);
    sel_mode_i = 3'd5;
    csr_elem_size_i = 8;
    start_i = 1'b1;
    addr_ready_i = 1'b0;
    lowdim_data_i = beats_q[0];
    lowdim_data_valid_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("clr_pre_valid", 64'(addr_valid_o), 64'd1);
    chk("clr_pre_busy", 64'(busy_o), 64'd1);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    lowdim_data_valid_i = 1'b0;
    chk("clr_fifo_empty", 64'(addr_valid_o), 64'd0);
    chk("clr_idle", 64'(busy_o), 64'd0);
    chk("clr_no_done", 64'(done_o), 64'd0);
    @(negedge clk_i);
    chk("clr_no_done_late", 64'(done_o), 64'd0);
    run_job(3'd5, 8, 1'b0, 1'b0, 0, "b16_restart");

    // random jobs with random handshakes, including reserved modes
    for (int j = 0; j < 8; j++) begin
      m = 3'($urandom_range(0, 7));
      csr_base_addr_i = AW'($urandom_range(0, 1023));
      beats_q.delete();
      for (int b = 0; b < 24; b++) beats_q.push_back({$urandom, $urandom});
      run_job(m, $urandom_range(0, 20), 1'b1, 1'b1, 0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
